// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one step per cycle, holding the pipeline via stall_req until the result is presented.
module muldiv_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] op_a_E,
  input  logic [XLEN-1:0] op_b_E,
  input  logic            flush_E,
  output logic            stall_req,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sgnA;
  logic              w_sgnB;
  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_aMag;
  logic [XLEN-1:0]   w_bMag;
  logic              w_divZero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fastVal;
  logic              w_lastIter;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_hiNext;
  logic [XLEN-1:0]   w_loNext;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_mulRes;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_divRes;
  logic [XLEN-1:0]   w_finalRes;

  // Operand decode at acceptance: signedness, magnitudes and fast-path detection
  assign w_accept  = (r_state == IDLE) && start_E && !flush_E;
  assign w_sgnA    = (funct3_E == 3'b001) || (funct3_E == 3'b010) ||
                     (funct3_E == 3'b100) || (funct3_E == 3'b110);
  assign w_sgnB    = (funct3_E == 3'b001) || (funct3_E == 3'b100) || (funct3_E == 3'b110);
  assign w_aNeg    = w_sgnA && op_a_E[XLEN-1];
  assign w_bNeg    = w_sgnB && op_b_E[XLEN-1];
  assign w_aMag    = w_aNeg ? -op_a_E : op_a_E;
  assign w_bMag    = w_bNeg ? -op_b_E : op_b_E;
  assign w_divZero = funct3_E[2] && (op_b_E == '0);
  assign w_ovf     = funct3_E[2] && !funct3_E[0] &&
                     (op_a_E == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_E == '1);
  assign w_fast    = w_divZero || w_ovf;

  always_comb begin
    w_fastVal = '0;
    if (w_divZero)
      w_fastVal = funct3_E[1] ? op_a_E : '1;
    else if (w_ovf)
      w_fastVal = funct3_E[1] ? '0 : op_a_E;
  end

  // One iteration: r_hi/r_lo hold product halves (multiply) or remainder/quotient (divide)
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  always_comb begin
    w_hiNext = w_sum[XLEN:1];
    w_loNext = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_f3[2]) begin
      if (!w_trial[XLEN]) begin
        w_hiNext = w_trial[XLEN-1:0];
        w_loNext = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hiNext = w_shift[XLEN-1:0];
        w_loNext = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_prod     = {w_hiNext, w_loNext};
  assign w_prodFix  = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_mulRes   = (r_f3[1:0] == 2'b00) ? w_prodFix[XLEN-1:0] : w_prodFix[2*XLEN-1:XLEN];
  assign w_quot     = (r_sa ^ r_sb) ? -w_loNext : w_loNext;
  assign w_rem      = r_sa ? -w_hiNext : w_hiNext;
  assign w_divRes   = r_f3[1] ? w_rem : w_quot;
  assign w_finalRes = r_f3[2] ? w_divRes : w_mulRes;
  assign w_lastIter = (r_cnt == CNT_W'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall_req = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall_req = 1'b1;
          w_next    = w_fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_E) begin
          w_next = IDLE;
        end else begin
          stall_req = 1'b1;
          if (w_lastIter)
            w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The final value is registered on the edge entering DONE so it holds afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_f3  <= funct3_E;
      r_sa  <= w_aNeg;
      r_sb  <= w_bNeg;
      r_hi  <= '0;
      r_lo  <= w_aMag;
      r_b   <= w_bMag;
      r_cnt <= '0;
      if (w_fast)
        r_result <= w_fastVal;
    end else if ((r_state == CALC) && !flush_E) begin
      r_hi  <= w_hiNext;
      r_lo  <= w_loNext;
      r_cnt <= r_cnt + 1'b1;
      if (w_lastIter)
        r_result <= w_finalRes;
    end
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign result       = r_result;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed RV32M cases, flush/reset scenarios and
// randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_E;
  logic [2:0]  funct3_E;
  logic [31:0] op_a_E;
  logic [31:0] op_b_E;
  logic        flush_E;
  logic        stall_req;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int totalCount;
  int badCount;

  muldiv_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_E      (start_E),
    .funct3_E     (funct3_E),
    .op_a_E       (op_a_E),
    .op_b_E       (op_b_E),
    .flush_E      (flush_E),
    .stall_req    (stall_req),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference result from the RV32M definitions using 64-bit integer arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] up;
    sa = a;
    sb = b;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'(ub); up = sp; return up[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refStallCycles(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 33;
  endfunction

  // Issues one op, holds start_E while stalled and checks latency, result and one-cycle valid
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    int          expStall;
    int          stallCnt;
    logic        seen;
    expRes   = refResult(f3, a, b);
    expStall = refStallCycles(f3, a, b);
    stallCnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    start_E  = 1'b1;
    funct3_E = f3;
    op_a_E   = a;
    op_b_E   = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (stall_req) stallCnt++;
      @(negedge clk);
    end
    checkOutput("validSeen", seen, 1);
    checkOutput($sformatf("result f3=%0d a=%0h b=%0h", f3, a, b), result, expRes);
    checkOutput("stallLength", stallCnt, expStall);
    checkOutput("stallInDone", stall_req, 0);
    @(negedge clk);
    start_E = 1'b0;
    op_a_E  = $urandom;
    op_b_E  = $urandom;
    #1;
    checkOutput("validOneCycle", result_valid, 0);
    checkOutput("idleAfterDone", busy, 0);
    checkOutput("resultHold", result, expRes);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    totalCount = 0;
    badCount   = 0;
    rst_n      = 1'b0;
    start_E    = 1'b0;
    flush_E    = 1'b0;
    funct3_E   = 3'b000;
    op_a_E     = '0;
    op_b_E     = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetStall", stall_req, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetValid", result_valid, 0);
    checkOutput("resetResult", result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD);
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2);
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2);
    applyStimulus(3'b101, 32'd100, 32'd7);
    applyStimulus(3'b100, 32'd5, 32'd0);
    applyStimulus(3'b110, 32'd5, 32'd0);
    applyStimulus(3'b101, 32'd5, 32'd0);
    applyStimulus(3'b111, 32'd5, 32'd0);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(3'b101, 32'h80000000, 32'hFFFFFFFF);

    // Flush during CALC cycle 10 aborts without a result
    @(negedge clk);
    start_E  = 1'b1;
    funct3_E = 3'b000;
    op_a_E   = 32'd1234;
    op_b_E   = 32'd5678;
    repeat (11) @(negedge clk);
    flush_E = 1'b1;
    #1;
    checkOutput("flushStallDrop", stall_req, 0);
    checkOutput("flushBusyCalc", busy, 1);
    @(negedge clk);
    flush_E = 1'b0;
    start_E = 1'b0;
    #1;
    checkOutput("flushIdle", busy, 0);
    checkOutput("flushNoValid", result_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("flushStillNoValid", result_valid, 0);
    applyStimulus(3'b011, 32'd1234, 32'd5678);

    // Start and flush together in IDLE is not accepted
    @(negedge clk);
    start_E = 1'b1;
    flush_E = 1'b1;
    #1;
    checkOutput("startFlushStall", stall_req, 0);
    @(negedge clk);
    start_E = 1'b0;
    flush_E = 1'b0;
    #1;
    checkOutput("startFlushBusy", busy, 0);

    // Asynchronous reset in the middle of CALC
    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD);
    @(negedge clk);
    start_E  = 1'b1;
    funct3_E = 3'b101;
    op_a_E   = 32'd100;
    op_b_E   = 32'd7;
    repeat (6) @(negedge clk);
    start_E = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetStall", stall_req, 0);
    checkOutput("midResetValid", result_valid, 0);
    checkOutput("midResetResult", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postResetBusy", busy, 0);
    checkOutput("postResetValid", result_valid, 0);
    applyStimulus(3'b101, 32'd100, 32'd7);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(f3, a, b);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
